// File: rtl/fp_mant_mul_seq.sv
// Sequential WIDTH x WIDTH mantissa multiplier: streams one nibble pair per cycle
// through an external combinational 4x4 multiplier and accumulates the 2*WIDTH product.
module fp_mant_mul_seq #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [3:0]         nib_a,
  output logic [3:0]         nib_b,
  input  logic [7:0]         nib_p,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int NIBS = WIDTH / 4;
  localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   i, j;
  logic [WIDTH-1:0] a_r, b_r;
  logic [PW-1:0]   acc;

  logic [CW:0]     nib_sum;
  logic [CW+2:0]   sh;
  logic [PW-1:0]   term;
  logic [PW-1:0]   acc_nxt;
  logic            last_pair;

  // Nibble selects are only live in RUN so the external multiplier sees zeros otherwise.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    if (state == RUN) begin
      nib_a = a_r[{i, 2'b00} +: 4];
      nib_b = b_r[{j, 2'b00} +: 4];
    end
  end

  // Partial product weight is 16^(i+j); the 2*WIDTH accumulator cannot overflow.
  always_comb begin
    nib_sum   = {1'b0, i} + {1'b0, j};
    sh        = {nib_sum, 2'b00};
    term      = PW'(nib_p) << sh;
    acc_nxt   = acc + term;
    last_pair = (i == LAST) && (j == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (last_pair) begin
            p     <= acc_nxt;
            done  <= 1'b1;
            state <= DONE;
          end else if (j == LAST) begin
            j <= '0;
            i <= i + CW'(1);
          end else begin
            j <= j + CW'(1);
          end
        end
        DONE: begin
          // start is ignored here; the next request is sampled back in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
